// File: rtl/truth_sweep_checker.sv
// truth_sweep_checker: steps a 3-input combinational block through every input
// vector, holds each one for a programmable settle time, samples the block's
// output and compares it against an expected truth table.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; result registers hold the last sweep
//   SETTLE | vec driven, counting down the settle time
//   SAMPLE | capture dut_x for the current vec, then advance or finish
module truth_sweep_checker #(
  parameter int NUM_IN        = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter logic [(1<<NUM_IN)-1:0] EXPECTED = 'h90
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     dut_x,
  output logic [NUM_IN-1:0]        vec,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [NUM_IN:0]          err_count,
  output logic                     fail_valid,
  output logic [NUM_IN-1:0]        first_fail_idx,
  output logic [(1<<NUM_IN)-1:0]   captured,
  output logic                     aborted
);

  localparam int                ERR_W    = NUM_IN + 1;
  localparam logic [NUM_IN-1:0] LAST_VEC = NUM_IN'((1 << NUM_IN) - 1);
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   settle_cnt;
  logic         miss;
  logic [NUM_IN:0] err_next;

  // Compare the current sample against the expected bit and form the updated count.
  always_comb begin
    miss     = 1'b0;
    err_next = err_count;
    miss     = (dut_x != EXPECTED[vec]);
    err_next = err_count + ERR_W'(miss);
  end

  // Sweep sequencer: drives vec, times the settle window and records results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      settle_cnt     <= 4'd0;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
      captured       <= '0;
      aborted        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state          <= SETTLE;
            busy           <= 1'b1;
            vec            <= '0;
            settle_cnt     <= SETTLE_LOAD;
            captured       <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
            aborted        <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            vec     <= '0;
            aborted <= 1'b1;
          end else if (settle_cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          // abort on the sample edge discards this sample entirely
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            vec     <= '0;
            aborted <= 1'b1;
          end else begin
            captured[vec] <= dut_x;
            err_count     <= err_next;
            if (miss && !fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= vec;
            end
            if (vec != LAST_VEC) begin
              vec        <= vec + NUM_IN'(1);
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end else begin
              vec   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
